led_pwm_controller: RTL and testbench

Parametrised multi-channel LED driver for the board-level status LEDs. Each of `NUM_LEDS` channels is independently set, through a valid/ready configuration port, to off, on, blink at a programmable rate, fixed-duty PWM dimming, or a triangle "breathe" ramp. Configuration writes are shadowed and applied only at PWM period boundaries, so outputs never glitch mid-period. It sits between the switch/config logic and the LED pins.

---
 rtl/led_ctrl_pkg.sv | 14 +
 rtl/led_channel.sv | 97 +++++++++
 rtl/led_pwm_controller.sv | 70 +++++++
 tb/tb_led_pwm_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the multi-channel LED PWM driver.
package led_ctrl_pkg;

  localparam int CHAN_W = 4;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PWM     = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_t;

endpackage

// File: rtl/led_channel.sv
// One LED channel: shadow/active config, phase accumulator, mode mux and
// registered output. Shadow config is promoted only on a PWM period boundary.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  input  logic                 boundary,
  input  logic                 load,
  input  logic [2:0]           ld_mode,
  input  logic [ACC_WIDTH-1:0] ld_incr,
  input  logic [PWM_WIDTH-1:0] ld_duty,
  output logic                 pending,
  output logic                 led
);

  logic [2:0]           sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [ACC_WIDTH-1:0] sh_incr_q, sh_incr_d, act_incr_q, act_incr_d;
  logic [PWM_WIDTH-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 pending_q, pending_d;
  logic                 led_q, led_d;
  logic                 apply;
  logic [PWM_WIDTH-1:0] brth_duty;

  // apply uses the pre-edge pending, so a load on the boundary edge waits a period
  assign apply = boundary & pending_q;

  always_comb begin
    sh_mode_d  = sh_mode_q;
    sh_incr_d  = sh_incr_q;
    sh_duty_d  = sh_duty_q;
    act_mode_d = act_mode_q;
    act_incr_d = act_incr_q;
    act_duty_d = act_duty_q;
    pending_d  = pending_q & ~apply;
    acc_d      = acc_q + act_incr_q;
    if (load) begin
      sh_mode_d = ld_mode;
      sh_incr_d = ld_incr;
      sh_duty_d = ld_duty;
      pending_d = 1'b1;
    end
    if (apply) begin
      act_mode_d = sh_mode_q;
      act_incr_d = sh_incr_q;
      act_duty_d = sh_duty_q;
      acc_d      = '0;
    end
  end

  // Triangle ramp: rising half uses the top bits below the MSB, falling half inverts them
  always_comb begin
    brth_duty = acc_q[ACC_WIDTH-2 -: PWM_WIDTH];
    if (acc_q[ACC_WIDTH-1]) brth_duty = ~brth_duty;
    led_d = 1'b0;
    case (mode_t'(act_mode_q))
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = acc_q[ACC_WIDTH-1];
      MODE_PWM:     led_d = (pwm_cnt < act_duty_q);
      MODE_BREATHE: led_d = (pwm_cnt < brth_duty);
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_mode_q  <= '0;
      sh_incr_q  <= '0;
      sh_duty_q  <= '0;
      act_mode_q <= '0;
      act_incr_q <= '0;
      act_duty_q <= '0;
      acc_q      <= '0;
      pending_q  <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      sh_mode_q  <= sh_mode_d;
      sh_incr_q  <= sh_incr_d;
      sh_duty_q  <= sh_duty_d;
      act_mode_q <= act_mode_d;
      act_incr_q <= act_incr_d;
      act_duty_q <= act_duty_d;
      acc_q      <= acc_d;
      pending_q  <= pending_d;
      led_q      <= led_d;
    end
  end

  assign pending = pending_q;
  assign led     = led_q;

endmodule

// File: rtl/led_pwm_controller.sv
// Multi-channel LED driver top: shared PWM counter, config decode and
// per-channel backpressure on the configuration port.
module led_pwm_controller
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS  = 4,
  parameter int ACC_WIDTH = 32,
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [2:0]           cfg_mode,
  input  logic [ACC_WIDTH-1:0] cfg_incr,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  output logic [NUM_LEDS-1:0]  led
);

  localparam int NUM_SLOTS = 1 << CHAN_W;

  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                 boundary;
  logic                 accept;
  logic [NUM_LEDS-1:0]  pending;
  logic [NUM_LEDS-1:0]  load;
  logic [NUM_SLOTS-1:0] pend_slot;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
  end

  assign boundary = &pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end

  // Unused slots read as not-pending, so out-of-range writes are always accepted
  always_comb begin
    pend_slot                = '0;
    pend_slot[NUM_LEDS-1:0]  = pending;
  end

  assign cfg_ready = ~reset & ~pend_slot[cfg_chan];
  assign accept    = cfg_valid & cfg_ready;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    assign load[i] = accept & (cfg_chan == CHAN_W'(i));

    led_channel #(
      .ACC_WIDTH (ACC_WIDTH),
      .PWM_WIDTH (PWM_WIDTH)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .pwm_cnt  (pwm_cnt_q),
      .boundary (boundary),
      .load     (load[i]),
      .ld_mode  (cfg_mode),
      .ld_incr  (cfg_incr),
      .ld_duty  (cfg_duty),
      .pending  (pending[i]),
      .led      (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_controller.sv
// Randomised and directed checks of led_pwm_controller against a
// period-level behavioural model held in the bench.
module tb_led_pwm_controller;

  localparam int NL = 3;
  localparam int AW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_chan;
  logic [2:0]    cfg_mode;
  logic [AW-1:0] cfg_incr;
  logic [PW-1:0] cfg_duty;
  logic [NL-1:0] led;

  led_pwm_controller #(.NUM_LEDS(NL), .ACC_WIDTH(AW), .PWM_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_incr(cfg_incr),
    .cfg_duty(cfg_duty), .led(led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int            pc;
  int            a_mode[NL], a_incr[NL], a_duty[NL], acc[NL];
  int            s_mode[NL], s_incr[NL], s_duty[NL];
  bit            pend[NL];
  logic [NL-1:0] m_led;
  logic          obs_ready, exp_ready;
  int            t_pc;

  function automatic bit led_fn(input int md, input int a, input int d, input int p);
    int tri_d;
    tri_d = (a < 128) ? a / 8 : 15 - (a - 128) / 8;
    case (md)
      1:       return 1'b1;
      2:       return a >= 128;
      3:       return p < d;
      4:       return p < tri_d;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive inputs, sample cfg_ready, step the model, settle outputs.
  task automatic tick(input bit rst, input bit v, input int ch, input int md,
                      input int inc, input int dt);
    bit take;
    reset = rst; cfg_valid = v; cfg_chan = 4'(ch); cfg_mode = 3'(md);
    cfg_incr = 8'(inc); cfg_duty = 4'(dt);
    #1;
    obs_ready = cfg_ready;
    exp_ready = !rst && !((ch < NL) ? pend[ch] : 1'b0);
    t_pc = pc;
    @(posedge clk);
    if (rst) begin
      pc = 0; m_led = '0;
      for (int i = 0; i < NL; i++) begin
        a_mode[i] = 0; a_incr[i] = 0; a_duty[i] = 0; acc[i] = 0;
        s_mode[i] = 0; s_incr[i] = 0; s_duty[i] = 0; pend[i] = 0;
      end
    end else begin
      take = v && exp_ready;
      for (int i = 0; i < NL; i++) m_led[i] = led_fn(a_mode[i], acc[i], a_duty[i], pc);
      for (int i = 0; i < NL; i++) begin
        if (pc == 15 && pend[i]) begin
          a_mode[i] = s_mode[i]; a_incr[i] = s_incr[i]; a_duty[i] = s_duty[i];
          acc[i] = 0; pend[i] = 0;
        end else begin
          acc[i] = (acc[i] + a_incr[i]) % 256;
        end
      end
      if (take && ch < NL) begin
        s_mode[ch] = md; s_incr[ch] = inc; s_duty[ch] = dt; pend[ch] = 1;
      end
      pc = (pc + 1) % 16;
    end
    #1;
  endtask

  task automatic settle(input int ch);
    for (int n = 0; n < 40 && pend[ch]; n++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    tick(0, 1, 0, 1, 0, 0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL reset_pre_ready got=%b want=1", obs_ready); end
    settle(0);
    for (int n = 0; n < 3; n++) tick(0, 0, 0, 0, 0, 0);
    total++; if (led[0] !== 1'b1) begin bad++; $display("FAIL reset_pre_on got=%b want=1", led[0]); end
    for (int n = 0; n < 3; n++) begin
      tick(1, 1, 1, 1, 0, 0);
      total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", obs_ready); end
      total++; if (led !== 3'b000) begin bad++; $display("FAIL reset_led got=%b want=000", led); end
    end
    tick(0, 0, 0, 0, 0, 0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", obs_ready); end
    for (int n = 0; n < 20; n++) begin
      tick(0, 0, 0, 0, 0, 0);
      total++; if (led !== 3'b000 || led !== m_led) begin bad++; $display("FAIL reset_no_write got=%b want=000", led); end
    end
  endtask

  task automatic test_pwm_duty4;
    int cnt, first;
    tick(0, 1, 0, 3, 0, 4);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL pwm4_ready got=%b want=1", obs_ready); end
    settle(0);
    total++; if (led[0] !== 1'b0) begin bad++; $display("FAIL pwm4_at_boundary got=%b want=0", led[0]); end
    cnt = 0; first = -1;
    for (int k = 1; k <= 16; k++) begin
      tick(0, 0, 0, 0, 0, 0);
      total++; if (led !== m_led) begin bad++; $display("FAIL pwm4_model got=%b want=%b", led, m_led); end
      if (led[0] === 1'b1) begin cnt++; if (first < 0) first = k; end
    end
    total++; if (cnt != 4) begin bad++; $display("FAIL pwm4_count got=%0d want=4", cnt); end
    total++; if (first != 1) begin bad++; $display("FAIL pwm4_first got=%0d want=1", first); end
  endtask

  task automatic test_pwm_extremes;
    int c1, c2;
    tick(0, 1, 1, 3, 0, 0);
    tick(0, 1, 2, 3, 0, 15);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL ext_ready got=%b want=1", obs_ready); end
    settle(1); settle(2);
    c1 = 0; c2 = 0;
    for (int k = 0; k < 16; k++) begin
      tick(0, 0, 0, 0, 0, 0);
      total++; if (led !== m_led) begin bad++; $display("FAIL ext_model got=%b want=%b", led, m_led); end
      if (led[1] === 1'b1) c1++;
      if (led[2] === 1'b1) c2++;
    end
    total++; if (c1 != 0)  begin bad++; $display("FAIL ext_duty0 got=%0d want=0", c1); end
    total++; if (c2 != 15) begin bad++; $display("FAIL ext_duty15 got=%0d want=15", c2); end
  endtask

  task automatic test_blink;
    logic want;
    int   cnt;
    tick(0, 1, 2, 2, 16, 0);
    settle(2);
    cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      tick(0, 0, 0, 0, 0, 0);
      want = ((k - 1) / 8) % 2;
      total++; if (led[2] !== want) begin bad++; $display("FAIL blink_k%0d got=%b want=%b", k, led[2], want); end
      if (led[2] === 1'b1) cnt++;
    end
    total++; if (cnt != 16) begin bad++; $display("FAIL blink_count got=%0d want=16", cnt); end
  endtask

  task automatic test_back_to_back;
    int stalls, acc_pc;
    for (int n = 0; n < 16 && pc != 3; n++) tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 2, 32, 0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b want=1", obs_ready); end
    tick(0, 1, 1, 3, 0, 9);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL b2b_other_chan got=%b want=1", obs_ready); end
    tick(0, 1, 3, 1, 0, 0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL b2b_oob_ready got=%b want=1", obs_ready); end
    total++; if (led !== m_led) begin bad++; $display("FAIL b2b_oob_led got=%b want=%b", led, m_led); end
    stalls = 0; acc_pc = -1;
    for (int n = 0; n < 40; n++) begin
      tick(0, 1, 0, 3, 0, 7);
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL b2b_hold_ready got=%b want=%b", obs_ready, exp_ready); end
      total++; if (led !== m_led) begin bad++; $display("FAIL b2b_hold_led got=%b want=%b", led, m_led); end
      if (obs_ready === 1'b1) begin acc_pc = t_pc; break; end
      stalls++;
    end
    total++; if (acc_pc != 0) begin bad++; $display("FAIL b2b_accept_phase got=%0d want=0", acc_pc); end
    total++; if (stalls != 10) begin bad++; $display("FAIL b2b_stalls got=%0d want=10", stalls); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 15));
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, obs_ready, exp_ready); end
      total++; if (led !== m_led) begin bad++; $display("FAIL rand_led n=%0d got=%b want=%b", n, led, m_led); end
    end
  endtask

  task automatic test_reset_mid_op;
    for (int n = 0; n < 20; n++) tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 4, 1, 0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL mid_breathe_ready got=%b want=1", obs_ready); end
    settle(0);
    for (int n = 0; n < 40; n++) begin
      tick(0, 0, 0, 0, 0, 0);
      total++; if (led !== m_led) begin bad++; $display("FAIL mid_breathe got=%b want=%b", led, m_led); end
    end
    for (int n = 0; n < 16 && pc != 2; n++) tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 1, 0, 0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL mid_ch1_ready got=%b want=1", obs_ready); end
    tick(1, 0, 0, 0, 0, 0);
    total++; if (led !== 3'b000) begin bad++; $display("FAIL mid_reset_led got=%b want=000", led); end
    for (int n = 0; n < 40; n++) begin
      tick(0, 0, 0, 0, 0, 0);
      total++; if (led !== 3'b000) begin bad++; $display("FAIL mid_discard got=%b want=000", led); end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0;
    cfg_incr = '0; cfg_duty = '0; m_led = '0; pc = 0;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    test_reset;
    test_pwm_duty4;
    test_pwm_extremes;
    test_blink;
    test_back_to_back;
    test_random;
    test_reset_mid_op;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
